// File: rtl/cv32e40p_pkg2.sv
// Shared types for the RI5CY instruction prefetch queue.
// Holds the FSM state encoding and the buffered fetch entry.
package cv32e40p_pkg2;

  localparam int PREFETCH_DEPTH_DEFAULT = 2;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } prefetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } prefetch_entry_t;

endpackage

// File: rtl/cv32e40p_prefetch_fifo.sv
// Small synchronous FIFO of prefetched instruction words.
// Clear wins over push and pop in the same cycle.
import cv32e40p_pkg2::*;

module cv32e40p_prefetch_fifo #(
  parameter int DEPTH = PREFETCH_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  prefetch_entry_t din,
  output prefetch_entry_t dout,
  output logic            empty,
  output logic [3:0]      count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  prefetch_entry_t mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [3:0]      cnt;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      cnt <= cnt + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/cv32e40p_prefetch_queue.sv
// Prefetch stage: OBI fetch FSM, credit/discard bookkeeping,
// branch redirect and the buffered word FIFO.
import cv32e40p_pkg2::*;

module cv32e40p_prefetch_queue #(
  parameter int DEPTH = PREFETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  prefetch_state_e state, state_n;

  logic [31:0] fetch_addr, fetch_addr_n;
  logic [31:0] resp_addr, resp_addr_n;
  logic [31:0] pend_addr, pend_addr_n;
  logic [31:0] target;
  logic        branch_pending, branch_pending_n;
  logic [3:0]  outstanding, outstanding_n;
  logic [3:0]  discard, discard_n;
  logic [3:0]  count, count_n;
  logic        gnt, push, pop, empty;
  logic        credit, credit_n;
  logic        addr_lsb_unused;

  prefetch_entry_t din, head;

  assign addr_lsb_unused = ^branch_addr_i[1:0];
  assign target = {branch_addr_i[31:2], 2'b00};

  assign gnt  = (state == WAIT_GNT) && instr_gnt_i;
  // A response landing with a branch belongs to the old stream.
  assign push = instr_rvalid_i && !branch_i && (discard == '0);
  assign pop  = !empty && fetch_ready_i && !branch_i;

  assign din = '{
    addr:  resp_addr,
    rdata: instr_rdata_i,
    err:   instr_err_i
  };

  assign outstanding_n = outstanding + 4'(gnt)
                       - 4'(instr_rvalid_i);
  assign count_n = branch_i ? '0
                 : count + 4'(push) - 4'(pop);

  assign credit   = (5'(outstanding) + 5'(count))
                  < 5'(DEPTH);
  assign credit_n = (5'(outstanding_n) + 5'(count_n))
                  < 5'(DEPTH);

  cv32e40p_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (branch_i),
    .din   (din),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_n          = state;
    fetch_addr_n     = fetch_addr;
    resp_addr_n      = resp_addr;
    pend_addr_n      = pend_addr;
    branch_pending_n = branch_pending;
    discard_n        = discard;

    if (instr_rvalid_i && (discard != '0)) begin
      discard_n = discard_n - 4'd1;
    end
    if (gnt && branch_pending) begin
      discard_n = discard_n + 4'd1;
    end
    if (push) resp_addr_n = resp_addr + 32'd4;

    unique case (state)
      IDLE: begin
        if (branch_i) begin
          fetch_addr_n = target;
        end else if (req_i && credit) begin
          state_n = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (gnt) begin
          fetch_addr_n = branch_pending ? pend_addr
                       : fetch_addr + 32'd4;
          if (branch_i) fetch_addr_n = target;
          branch_pending_n = 1'b0;
          state_n = (req_i && credit_n && !branch_pending)
                  ? WAIT_GNT : IDLE;
        end else if (branch_i) begin
          // OBI forbids changing a live request address.
          branch_pending_n = 1'b1;
          pend_addr_n      = target;
        end
      end
      default: state_n = IDLE;
    endcase

    if (branch_i) begin
      resp_addr_n = target;
      discard_n   = outstanding_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      fetch_addr     <= '0;
      resp_addr      <= '0;
      pend_addr      <= '0;
      branch_pending <= 1'b0;
      outstanding    <= '0;
      discard        <= '0;
    end else begin
      state          <= state_n;
      fetch_addr     <= fetch_addr_n;
      resp_addr      <= resp_addr_n;
      pend_addr      <= pend_addr_n;
      branch_pending <= branch_pending_n;
      outstanding    <= outstanding_n;
      discard        <= discard_n;
    end
  end

  assign fetch_valid_o = !empty;
  assign fetch_rdata_o = empty ? '0 : head.rdata;
  assign fetch_addr_o  = empty ? '0 : head.addr;
  assign fetch_err_o   = !empty && head.err;

  assign instr_req_o  = (state == WAIT_GNT);
  assign instr_addr_o = fetch_addr;

  assign busy_o = (outstanding != '0) || !empty
               || branch_pending;

endmodule

// File: tb/tb_cv32e40p_prefetch_queue.sv
// Scoreboard bench for the prefetch queue with a simple
// in-order OBI memory model of configurable latency.
module tb_cv32e40p_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_err_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b1;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          due_q[$];
  logic [31:0] addr_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_gnt = 0;
  logic        hold = 1'b1;
  logic [31:0] err_addr = 32'h1;

  cv32e40p_prefetch_queue #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_err_o    (fetch_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: grants seen at negedge, data returned in order.
  always begin : bus
    int due;
    int last_due;
    last_due = 0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_req_o && instr_gnt_i) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        addr_q.push_back(instr_addr_o);
        n_gnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
      if (!rst_n) begin
        due_q.delete();
        addr_q.delete();
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = word(addr_q[0]);
        instr_err_i    = (addr_q[0] == err_addr);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
    end
  end

  // Consumer + scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    fetch_ready_i = rst_n && !hold && !branch_i
                 && (exp_q.size() > 0);
    if (fetch_ready_i && fetch_valid_o) begin
      e = exp_q.pop_front();
      checks++;
      if (fetch_addr_o !== e.addr ||
          fetch_rdata_o !== e.rdata ||
          fetch_err_o !== e.err) begin
        errors++;
        $display("FAIL word got %h/%h/%b exp %h/%h/%b",
                 fetch_addr_o, fetch_rdata_o, fetch_err_o,
                 e.addr, e.rdata, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] a,
                             input logic e);
    exp_q.push_back('{addr: a, rdata: word(a), err: e});
  endtask

  task automatic branch_to(input logic [31:0] a);
    branch_i      = 1'b1;
    branch_addr_i = a;
    step();
    branch_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout left %0d exp 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(fetch_valid_o), 0);
    chk({tag, "_rdata"}, fetch_rdata_o, 0);
    chk({tag, "_addr"},  fetch_addr_o, 0);
    chk({tag, "_err"},   32'(fetch_err_o), 0);
    chk({tag, "_req"},   32'(instr_req_o), 0);
    chk({tag, "_iaddr"}, instr_addr_o, 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int g0;
    int n;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Linear fetch from 0x1000.
    req_i = 1'b1;
    hold  = 1'b0;
    expect_word(32'h0000_1000, 1'b0);
    expect_word(32'h0000_1004, 1'b0);
    expect_word(32'h0000_1008, 1'b0);
    branch_to(32'h0000_1000);
    drain("seq1000");

    // Stalled consumer: buffer full, requests stop.
    repeat (10) step();
    hold = 1'b1;
    expect_word(32'h0000_100C, 1'b0);
    expect_word(32'h0000_1010, 1'b0);
    expect_word(32'h0000_1014, 1'b0);
    g0 = n_gnt;
    repeat (10) step();
    chk("hold_gnts", 32'(n_gnt - g0), 0);
    chk("hold_req", 32'(instr_req_o), 0);
    chk("hold_valid", 32'(fetch_valid_o), 1);
    hold = 1'b0;
    drain("resume");

    // Branch with two transactions in flight.
    hold = 1'b1;
    repeat (10) step();
    lat = 3;
    branch_to(32'h0000_5000);
    n = 0;
    while (due_q.size() != 2 && n < 30) begin
      step();
      n++;
    end
    chk("two_outstanding", 32'(due_q.size()), 2);
    expect_word(32'h0000_2000, 1'b0);
    expect_word(32'h0000_2004, 1'b0);
    hold = 1'b0;
    branch_to(32'h0000_2000);
    drain("seq2000");
    lat = 1;

    // Branch while a request waits for grant.
    hold = 1'b1;
    branch_to(32'h0000_6000);
    repeat (10) step();
    instr_gnt_i = 1'b0;
    branch_to(32'h0000_7000);
    n = 0;
    while (!instr_req_o && n < 20) begin
      step();
      n++;
    end
    chk("pend_req", 32'(instr_req_o), 1);
    chk("pend_addr0", instr_addr_o, 32'h0000_7000);
    expect_word(32'h0000_3000, 1'b0);
    expect_word(32'h0000_3004, 1'b0);
    branch_to(32'h0000_3000);
    chk("pend_addr1", instr_addr_o, 32'h0000_7000);
    step();
    chk("pend_addr2", instr_addr_o, 32'h0000_7000);
    step();
    chk("pend_addr3", instr_addr_o, 32'h0000_7000);
    chk("pend_busy", 32'(busy_o), 1);
    instr_gnt_i = 1'b1;
    hold = 1'b0;
    drain("seq3000");

    // Error response on 0x1004.
    err_addr = 32'h0000_1004;
    expect_word(32'h0000_1000, 1'b0);
    expect_word(32'h0000_1004, 1'b1);
    expect_word(32'h0000_1008, 1'b0);
    branch_to(32'h0000_1000);
    drain("err1004");
    err_addr = 32'h1;

    // Address wrap, then reset mid-burst.
    expect_word(32'hFFFF_FFF8, 1'b0);
    expect_word(32'hFFFF_FFFC, 1'b0);
    expect_word(32'h0000_0000, 1'b0);
    branch_to(32'hFFFF_FFF8);
    drain("wrap");
    rst_n = 1'b0;
    step();
    check_zero("midrst");
    step();
    rst_n = 1'b1;
    step();

    // Recovery after reset, then quiesce.
    expect_word(32'h0000_0040, 1'b0);
    branch_to(32'h0000_0040);
    drain("post_rst");
    req_i = 1'b0;
    hold  = 1'b1;
    branch_to(32'h0000_0080);
    repeat (8) step();
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_req", 32'(instr_req_o), 0);
    chk("idle_valid", 32'(fetch_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_prefetch_queue.md
# cv32e40p_prefetch_queue

Instruction prefetch stage of the RI5CY core. Issues word fetches on the OBI instruction bus, tracks outstanding transactions, and buffers returned words with their addresses and error flags. Presents them to the IF/aligner stage through a valid/ready port. On a branch it flushes its buffer, discards stale in-flight responses and redirects fetching.

## Interface
Parameters:
- DEPTH, default 2: FIFO entries; also the credit limit on outstanding plus buffered words (legal range 2..8).

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_i  in  1  fetch enable from the controller.
- branch_i  in  1  single-cycle flush/redirect strobe.
- branch_addr_i  in  32  redirect target; bits [1:0] are ignored.
- fetch_valid_o  out  1  head entry is valid.
- fetch_ready_i  in  1  consumer accepts the head entry.
- fetch_rdata_o  out  32  head instruction word.
- fetch_addr_o  out  32  word address of the head entry.
- fetch_err_o  out  1  bus error flag of the head entry.
- instr_req_o  out  1  OBI request.
- instr_gnt_i  in  1  OBI grant.
- instr_addr_o  out  32  OBI address, always word-aligned.
- instr_rvalid_i  in  1  OBI response valid.
- instr_rdata_i  in  32  OBI response data.
- instr_err_i  in  1  OBI response error.
- busy_o  out  1  outstanding > 0, or FIFO not empty, or a pending branch exists.

## Operation
- **Reset values.** While rst_n=0 at a clock edge:
  - all outputs go to 0;
  - state=IDLE;
  - fetch_addr register=0, resp_addr=0;
  - outstanding=0, discard=0;
  - FIFO empty, branch_pending=0.
- **Credit.** credit = (outstanding + fifo_count < DEPTH). Discarded-but-outstanding transactions count toward the limit.
- **FSM, IDLE.** instr_req_o=0. Move to WAIT_GNT when req_i && credit && !branch_i.
- **FSM, WAIT_GNT.** instr_req_o=1, with instr_addr_o held stable until grant (OBI rule).
- **On grant** (instr_gnt_i in WAIT_GNT):
  - outstanding++;
  - fetch_addr <= fetch_addr+4, wrapping modulo 2^32;
  - stay in WAIT_GNT if req_i && credit-after-update && !branch_pending, else go to IDLE.
- **Branch in IDLE, or in WAIT_GNT with gnt in the same cycle:**
  - fetch_addr <= {branch_addr_i[31:2],2'b00};
  - resp_addr is set to the same value;
  - FIFO cleared;
  - discard <= outstanding + (gnt this cycle ? 1 : 0) − (accepted rvalid this cycle ? 1 : 0).
- **Branch in WAIT_GNT without gnt:**
  - store the target and set branch_pending; the request stays up unchanged;
  - on the eventual gnt, discard++ for that transaction, fetch_addr <= pending target, branch_pending cleared.
  - FIFO clear, resp_addr and the discard update happen in the branch cycle itself.
- **Response path (instr_rvalid_i):**
  - outstanding-- always;
  - if discard>0 (counter value before this cycle's branch update): drop the response and discard--;
  - else push {resp_addr, rdata, err} and resp_addr += 4.
  - An rvalid coinciding with branch_i is always dropped and never pushed.
- **Consumer pop.** fetch_valid_o && fetch_ready_i pops the head. A pop in a branch cycle is superseded by the clear.
- **Errors.** An error response is buffered like data with fetch_err_o=1. Fetching continues.
- **Overflow/underflow.** A push never finds the FIFO full, because the credit rule guarantees space. Simultaneous push and pop when full is legal.
- **Deassertion of req_i.** Dropping req_i while in WAIT_GNT does not withdraw the request; the FSM leaves only on grant.

## Timing
- instr_req_o is decoded from registered state: it rises one cycle after req_i is sampled with credit.
- Minimum fetch latency, gnt in the same cycle as req:
  - req_i at cycle 0;
  - instr_req_o/gnt at cycle 1;
  - rvalid at cycle 2 or later;
  - fetch_valid_o at the cycle after the rvalid (no fall-through).
- Back-to-back grants sustain 1 request/cycle while credit permits.
- branch_i at cycle n gives fetch_valid_o=0 from cycle n+1 until the first post-branch word is pushed.
- Reset mid-transaction abandons all bookkeeping. The bus must be reset together with the core.

## Structure
- cv32e40p_pkg2 holds:
  - PREFETCH_DEPTH_DEFAULT;
  - typedef enum prefetch_state_e {IDLE, WAIT_GNT};
  - packed struct prefetch_entry_t {addr[31:0], rdata[31:0], err}.
- Sub-module cv32e40p_prefetch_fifo: DEPTH-entry synchronous FIFO of prefetch_entry_t with push/pop/clear/count and sync active-low reset.
- The top level holds the FSM, counters, branch_pending and resp_addr.

## Test plan
- Reset, then branch to 0x0000_1000 with req_i=1, gnt always 1, rvalid one cycle after gnt → fetch_addr_o sequence 0x1000, 0x1004, 0x1008, with rdata matching the bus model; instr_req_o never high with outstanding+count=2 (DEPTH=2).
- Consumer holds fetch_ready_i=0 → at most 2 words buffered, instr_req_o drops, no words lost; releasing ready resumes at the next address.
- Branch to 0x2000 with 2 outstanding → both late rvalids dropped, next fetch_addr_o=0x2000, outstanding returns to 0.
- Branch to 0x3000 while instr_req_o=1 and gnt held low 3 cycles → instr_addr_o stays at the old address until gnt; the granted response is dropped; next request is 0x3000.
- instr_err_i=1 on the word at 0x1004 → fetch_err_o=1 only for that entry; fetching continues to 0x1008.
- Start fetching at 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst_n=0 asserted mid-burst → all outputs 0 after the next edge.
